bram_scan_ctrl: RTL and testbench
=================================

// Module: bram_scan_ctrl
// PURPOSE
//  Parametrised single-clock block RAM with a host write port, a direct single-word
//  read, and an auto-incrementing scan engine.
//  The scan engine streams a contiguous, wrap-around address range out over a
//  valid/ready interface.
//  Successor to the fixed 32x4 BRAM: it generalises width and depth and adds
//  back-pressure, burst scans and a completion flag.
// PARAMETERS
//  DATA_W  4  data word width in bits
//  ADDR_W  5  address width; depth DEPTH = 2**ADDR_W (localparam, power of two)
// PORTS
//  clk        in   1         rising-edge clock, sole clock domain
//  rst_n      in   1         asynchronous active-low reset
//  we         in   1         write enable; writes w_data to mem[addr] at clk edge
//  addr       in   ADDR_W    write/direct-read address
//  w_data     in   DATA_W    write data
//  rd_en      in   1         direct read request for mem[addr]
//  start      in   1         scan request, single-cycle pulse
//  scan_base  in   ADDR_W    first scan address
//  scan_len   in   ADDR_W+1  scan word count
//  r_ready    in   1         sink ready
//  r_data     out  DATA_W    read data
//  r_valid    out  1         r_data valid; beat transfers when r_valid & r_ready
//  r_last     out  1         final beat of a scan, or any direct-read beat
//  busy       out  1         scan active or output buffer non-empty
//  done       out  1         1-cycle pulse on the last scan beat transfer
// BEHAVIOUR
//  - Reset (async assert, sync release): r_data=0, r_valid=0, r_last=0, busy=0,
//    done=0, FSM=IDLE, output buffer flushed.
//  - Memory contents are NOT reset; they persist across reset, including a
//    reset asserted mid-scan.
//  - Writes are accepted every cycle in every state.
//  - Same-cycle write and read of the same address is read-first: the read
//    returns the old data.
//  - FSM states IDLE, SCAN, DRAIN.
//    - IDLE->SCAN: start=1, busy=0, scan_len!=0.
//    - SCAN->DRAIN: last read issued.
//    - DRAIN->IDLE: last beat transferred.
//  - start is ignored while busy=1, and ignored when scan_len==0 (no beats, no done).
//  - scan_len>DEPTH is clamped to DEPTH; each word is read at most once per scan.
//  - Scan address sequence: (scan_base+i) mod DEPTH, i=0..len-1.
//    Natural wrap from DEPTH-1 to 0.
//  - rd_en is accepted only when busy=0 and start=0; start wins if both are high.
//  - An accepted direct read produces one beat with r_last=1 and no done pulse.
//  - Direct-read latency: rd_en sampled at edge k -> r_valid=1 after edge k+1.
//  - Scan latency: start sampled at edge k -> first beat valid after edge k+2.
//  - Throughput is 1 beat/cycle while r_ready=1.
//  - Back-pressure: while r_valid=1 and r_ready=0, r_data/r_last are held stable.
//    - No beat is dropped, duplicated or reordered.
//    - The RAM read pipeline is backed by a 2-entry skid buffer.
//  - done is asserted in the same cycle as the r_last beat handshake of a scan.
//  - busy stays 1 until that handshake completes.
//  - start/rd_en/we inputs are sampled only on the clk edge; no combinational
//    path from inputs to outputs.
// TESTING
//  1. Write mem[i]=i[3:0]^4'hA for i=0..31; direct read addr 5 -> one beat
//     r_data=4'hF, r_last=1, no done.
//  2. Scan base=0 len=32, r_ready=1 -> 32 back-to-back beats of i^A.
//     r_last=1 and done=1 on beat 32 only; busy falls the next cycle.
//  3. Wrap: base=30 len=4 -> beats 4'h4,4'h5,4'hA,4'hB; last beat flagged.
//  4. Back-pressure: base=8 len=8, r_ready toggling 1,0,1,0... ->
//     beats 2,3,0,1,6,7,4,5 in order; r_data stable in every stalled cycle.
//  5. Guards: start with len=0 -> busy stays 0, no beat.
//     len=40 -> exactly 32 beats.
//     rd_en while busy -> ignored.
//     start+rd_en in the same cycle -> scan only.
//  6. rst_n low after beat 3 of a len-16 scan -> r_valid=0, busy=0 immediately.
//     After release, direct read addr 7 -> 4'hD, showing memory is retained.

Source files
------------

// File: rtl/bram_scan_ctrl.sv
// Single-clock block RAM with host write port, direct single-word read and an
// auto-incrementing wrap-around scan engine streaming over valid/ready.
module bram_scan_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] scan_base,
  input  logic [ADDR_W:0]   scan_len,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_clamped;

  logic              pipe_vld;
  logic              pipe_last;
  logic [DATA_W-1:0] pipe_data;

  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] slot0_data, slot1_data;
  logic              slot0_last, slot1_last;

  logic              pop, room, start_ok, rd_issue, scan_issue;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] rd_addr;

  assign r_valid = (fifo_cnt != 2'd0);
  assign r_data  = slot0_data;
  assign r_last  = slot0_last & r_valid;
  assign pop     = r_valid & r_ready;
  assign busy    = (state != IDLE) | pipe_vld | r_valid;
  // Only a scan can be in flight while in DRAIN, so any last beat there is the scan's.
  assign done    = pop & slot0_last & (state == DRAIN);

  // A new read may be issued only if the skid buffer can still absorb it
  // after whatever moves this cycle.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, pipe_vld} - {2'b00, pop};
  assign room      = (occupancy < 3'd2);

  assign len_clamped = (scan_len > DEPTH_LEN) ? DEPTH_LEN : scan_len;
  assign start_ok    = start & ~busy & (scan_len != '0);
  assign rd_issue    = rd_en & ~busy & ~start;
  assign scan_issue  = (state == SCAN) & (remaining != '0) & room;
  assign rd_addr     = scan_issue ? cur_addr : addr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SCAN;
      SCAN:    if (scan_issue && (remaining == LEN_ONE)) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pipe_vld  <= 1'b0;
      pipe_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      pipe_vld  <= scan_issue | rd_issue;
      pipe_last <= rd_issue | (scan_issue & (remaining == LEN_ONE));
      if (start_ok) begin
        cur_addr  <= scan_base;
        remaining <= len_clamped;
      end else if (scan_issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - LEN_ONE;
      end
    end
  end

  // Memory contents and the raw read register are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= w_data;
    if (scan_issue || rd_issue) pipe_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt   <= 2'd0;
      slot0_data <= '0;
      slot0_last <= 1'b0;
      slot1_data <= '0;
      slot1_last <= 1'b0;
    end else begin
      case (fifo_cnt)
        2'd0: begin
          if (pipe_vld) begin
            slot0_data <= pipe_data;
            slot0_last <= pipe_last;
            fifo_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && pipe_vld) begin
            slot0_data <= pipe_data;
            slot0_last <= pipe_last;
          end else if (pipe_vld) begin
            slot1_data <= pipe_data;
            slot1_last <= pipe_last;
            fifo_cnt   <= 2'd2;
          end else if (pop) begin
            fifo_cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            slot0_data <= slot1_data;
            slot0_last <= slot1_last;
            if (pipe_vld) begin
              slot1_data <= pipe_data;
              slot1_last <= pipe_last;
            end else begin
              fifo_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Self-checking bench for bram_scan_ctrl: table-driven vectors, hand-written
// reset/read-first sequences and randomized operations against a memory model.
module tb_bram_scan_ctrl;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n, we, rd_en, start, r_ready;
  logic [ADDR_W-1:0] addr, scan_base;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W:0]   scan_len;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_last, busy, done;

  bram_scan_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .w_data(w_data),
    .rd_en(rd_en), .start(start), .scan_base(scan_base), .scan_len(scan_len),
    .r_ready(r_ready), .r_data(r_data), .r_valid(r_valid), .r_last(r_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       do_start;
    logic       do_rd;
    logic [4:0] a;
    logic [5:0] len;
    int         ready_mode;
    int         exp_beats;
    logic       rd_mid;
    logic       chk_first;
    logic [3:0] exp_first;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int passed = 0;

  logic [3:0] model_mem [DEPTH];
  logic [3:0] exp_q [$];
  logic [3:0] got_data [$];
  logic       got_last [$];
  logic       got_done [$];
  int first_valid, done_cycle, busy_fall, stall_viol, done_stray;
  logic busy_seen, timed_out;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input int a, input logic [3:0] d);
    we = 1'b1; addr = 5'(a); w_data = d;
    tick();
    we = 1'b0;
    model_mem[a] = d;
  endtask

  // Reference: a scan yields min(len,DEPTH) words from (base+i) mod DEPTH.
  function automatic void buildExpected(input logic do_start, input logic do_rd, input int a, input int len);
    int n;
    exp_q.delete();
    if (do_start) begin
      n = (len > DEPTH) ? DEPTH : len;
      for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(a + i) % DEPTH]);
    end else if (do_rd) begin
      exp_q.push_back(model_mem[a]);
    end
  endfunction

  task automatic applyStimulus(input logic do_start, input logic do_rd, input logic [4:0] a, input logic [5:0] len);
    start = do_start; rd_en = do_rd; addr = a; scan_base = a; scan_len = len;
    tick();
    start = 1'b0; rd_en = 1'b0;
  endtask

  task automatic runCollect(input int exp_n, input int ready_mode, input logic rd_mid);
    int cyc, settle;
    logic prev_stall, held_last;
    logic [3:0] held_data;
    got_data.delete(); got_last.delete(); got_done.delete();
    first_valid = -1; done_cycle = -1; busy_fall = -1;
    stall_viol = 0; done_stray = 0; busy_seen = 1'b0; timed_out = 1'b0;
    prev_stall = 1'b0; held_data = '0; held_last = 1'b0;
    cyc = 0; settle = 0;
    while (1) begin
      case (ready_mode)
        0:       r_ready = 1'b1;
        1:       r_ready = (cyc % 2 == 0);
        default: r_ready = 1'($urandom_range(0, 1));
      endcase
      rd_en = rd_mid && (cyc == 3);
      if (rd_mid) addr = 5'd5;
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (r_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (r_valid !== 1'b1 || r_data !== held_data || r_last !== held_last)) stall_viol++;
      prev_stall = r_valid && !r_ready;
      held_data = r_data;
      held_last = r_last;
      if (r_valid && r_ready) begin
        got_data.push_back(r_data);
        got_last.push_back(r_last);
        got_done.push_back(done);
      end else if (done) begin
        done_stray++;
      end
      if (done) done_cycle = cyc;
      if (done_cycle >= 0 && busy_fall < 0 && !busy) busy_fall = cyc;
      if (got_data.size() >= exp_n && !busy) settle++;
      tick();
      cyc++;
      if (settle >= 3) break;
      if (cyc >= 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    r_ready = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic compareBeats(input string tag, input logic is_scan, input int exp_beats);
    int n, last_bad, done_bad;
    n = exp_q.size();
    checkOutput({tag, " timeout"}, 32'(timed_out), 0);
    checkOutput({tag, " beats"}, got_data.size(), n);
    checkOutput({tag, " table_beats"}, got_data.size(), exp_beats);
    for (int i = 0; i < n && i < got_data.size(); i++)
      checkOutput($sformatf("%s data[%0d]", tag, i), 32'(got_data[i]), 32'(exp_q[i]));
    last_bad = 0;
    done_bad = done_stray;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_last[i] !== (i == n - 1)) last_bad++;
      if (got_done[i] !== (is_scan && (i == n - 1))) done_bad++;
    end
    checkOutput({tag, " last_flags"}, last_bad, 0);
    checkOutput({tag, " done_flags"}, done_bad, 0);
    checkOutput({tag, " stall_stable"}, stall_viol, 0);
    if (n > 0) checkOutput({tag, " latency"}, first_valid, is_scan ? 2 : 1);
    else       checkOutput({tag, " busy_idle"}, 32'(busy_seen), 0);
    if (is_scan && n > 0) checkOutput({tag, " busy_fall"}, busy_fall, done_cycle + 1);
  endtask

  initial begin
    int cnt, cyc, op, a, len, mode;
    logic [3:0] d;

    vecs[0] = '{"rd5",      1'b0, 1'b1, 5'd5,  6'd0,  0, 1,  1'b0, 1'b1, 4'hF};
    vecs[1] = '{"scan0_32", 1'b1, 1'b0, 5'd0,  6'd32, 0, 32, 1'b0, 1'b1, 4'hA};
    vecs[2] = '{"wrap30_4", 1'b1, 1'b0, 5'd30, 6'd4,  0, 4,  1'b0, 1'b1, 4'h4};
    vecs[3] = '{"bp8_8",    1'b1, 1'b0, 5'd8,  6'd8,  1, 8,  1'b0, 1'b1, 4'h2};
    vecs[4] = '{"len0",     1'b1, 1'b0, 5'd3,  6'd0,  0, 0,  1'b0, 1'b0, 4'h0};
    vecs[5] = '{"len40",    1'b1, 1'b0, 5'd3,  6'd40, 0, 32, 1'b0, 1'b1, 4'h9};
    vecs[6] = '{"start_rd", 1'b1, 1'b1, 5'd12, 6'd3,  0, 3,  1'b0, 1'b1, 4'h6};
    vecs[7] = '{"rd_busy",  1'b1, 1'b0, 5'd0,  6'd8,  0, 8,  1'b1, 1'b1, 4'hA};
    vecs[8] = '{"last31",   1'b1, 1'b0, 5'd31, 6'd1,  2, 1,  1'b0, 1'b1, 4'h5};

    rst_n = 1'b0; we = 1'b0; rd_en = 1'b0; start = 1'b0; r_ready = 1'b1;
    addr = '0; scan_base = '0; scan_len = '0; w_data = '0;
    #12;
    checkOutput("reset r_valid", 32'(r_valid), 0);
    checkOutput("reset r_last",  32'(r_last),  0);
    checkOutput("reset busy",    32'(busy),    0);
    checkOutput("reset done",    32'(done),    0);
    checkOutput("reset r_data",  32'(r_data),  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) writeWord(i, 4'(i) ^ 4'hA);

    for (int v = 0; v < 9; v++) begin
      buildExpected(vecs[v].do_start, vecs[v].do_rd, int'(vecs[v].a), int'(vecs[v].len));
      applyStimulus(vecs[v].do_start, vecs[v].do_rd, vecs[v].a, vecs[v].len);
      runCollect(exp_q.size(), vecs[v].ready_mode, vecs[v].rd_mid);
      compareBeats(vecs[v].name, vecs[v].do_start && (vecs[v].len != 0), vecs[v].exp_beats);
      if (vecs[v].chk_first && got_data.size() > 0)
        checkOutput({vecs[v].name, " first"}, 32'(got_data[0]), 32'(vecs[v].exp_first));
    end

    // Reset in the middle of a scan, then prove memory survived it.
    applyStimulus(1'b1, 1'b0, 5'd0, 6'd16);
    r_ready = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 3 && cyc < 100) begin
      @(negedge clk);
      if (r_valid && r_ready) cnt++;
      tick();
      cyc++;
    end
    checkOutput("rst_mid beats_before", cnt, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid r_valid", 32'(r_valid), 0);
    checkOutput("rst_mid busy",    32'(busy),    0);
    checkOutput("rst_mid done",    32'(done),    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_mid busy_after", 32'(busy), 0);
    buildExpected(1'b0, 1'b1, 7, 0);
    applyStimulus(1'b0, 1'b1, 5'd7, 6'd0);
    runCollect(1, 0, 1'b0);
    compareBeats("rst_retain", 1'b0, 1);
    if (got_data.size() > 0) checkOutput("rst_retain addr7", 32'(got_data[0]), 32'hD);

    // Same-cycle write and direct read of one address returns the old word.
    buildExpected(1'b0, 1'b1, 9, 0);
    we = 1'b1; w_data = 4'h7; rd_en = 1'b1; addr = 5'd9;
    tick();
    we = 1'b0; rd_en = 1'b0;
    model_mem[9] = 4'h7;
    runCollect(1, 0, 1'b0);
    compareBeats("read_first old", 1'b0, 1);
    buildExpected(1'b0, 1'b1, 9, 0);
    applyStimulus(1'b0, 1'b1, 5'd9, 6'd0);
    runCollect(1, 0, 1'b0);
    compareBeats("read_first new", 1'b0, 1);

    for (int r = 0; r < 40; r++) begin
      op = $urandom_range(0, 3);
      a = $urandom_range(0, DEPTH - 1);
      if (op <= 1) begin
        for (int k = 0; k < 4; k++) begin
          d = 4'($urandom_range(0, 15));
          writeWord($urandom_range(0, DEPTH - 1), d);
        end
      end else if (op == 2) begin
        mode = $urandom_range(0, 2);
        buildExpected(1'b0, 1'b1, a, 0);
        applyStimulus(1'b0, 1'b1, 5'(a), 6'd0);
        runCollect(1, mode, 1'b0);
        compareBeats($sformatf("rand%0d rd", r), 1'b0, 1);
      end else begin
        len = $urandom_range(0, 40);
        mode = $urandom_range(0, 2);
        buildExpected(1'b1, 1'b0, a, len);
        applyStimulus(1'b1, 1'b0, 5'(a), 6'(len));
        runCollect(exp_q.size(), mode, 1'b0);
        compareBeats($sformatf("rand%0d scan", r), len != 0, exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
